// File: rtl/ddrphy_dly_pkg.sv
// Shared types and helpers for the DDRPHY lane delay-line tap controller.
// Holds the controller state encoding, direction constants and the packed tap-slice helper.
package ddrphy_dly_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MOVE,
    ST_SETTLE,
    ST_DONE
  } dly_state_e;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  // LSB position of a lane's slice inside the packed current-tap bus.
  function automatic int unsigned tap_lsb(input int unsigned lane, input int unsigned tap_w);
    return lane * tap_w;
  endfunction

endpackage

// File: rtl/ddrphy_dly_settle_cnt.sv
// Loadable down-counter timing the idle window after each delay-line strobe.
// tc is asserted on the last enabled cycle of the window.
module ddrphy_dly_settle_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tc = en && (cnt_q == '0);

endmodule

// File: rtl/ddrphy_lane_delay_ctrl.sv
// Multi-lane IOD delay-line tap controller: loads or steps one lane per request,
// tracks each lane's tap count and flags out-of-range reported while settling.
module ddrphy_lane_delay_ctrl #(
  parameter int NUM_LANES     = 4,
  parameter int TAP_W         = 8,
  parameter int TAP_MAX       = 127,
  parameter int INIT_TAP      = 1,
  parameter int SETTLE_CYCLES = 4,
  parameter int LANE_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                       FAB_CLK,
  input  logic                       SYNC_RST,
  input  logic                       REQ_VALID,
  output logic                       REQ_READY,
  input  logic [LANE_W-1:0]          REQ_LANE,
  input  logic                       REQ_LOAD,
  input  logic [TAP_W-1:0]           REQ_TAP,
  output logic                       DONE,
  output logic                       DONE_ERR,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES*TAP_W-1:0] CUR_TAP,
  output logic [NUM_LANES-1:0]       OOR_STICKY
);

  import ddrphy_dly_pkg::*;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  dly_state_e state_q, state_d;

  logic [LANE_W-1:0]    lane_q;
  logic                 load_q;
  logic [TAP_W-1:0]     target_q;
  logic                 err_q;
  logic [TAP_W-1:0]     tap_q [NUM_LANES];
  logic [NUM_LANES-1:0] dir_q;
  logic [NUM_LANES-1:0] oor_q;

  logic [NUM_LANES-1:0] lane_oh, req_oh, move_stb, load_stb;
  logic [TAP_W-1:0]     cur_sel, req_cur;
  logic                 req_legal, step_start, accept, oor_now;
  logic                 settle_load, settle_tc;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    lane_oh = '0;
    req_oh  = '0;
    cur_sel = '0;
    req_cur = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_q == LANE_W'(i)) begin
        lane_oh[i] = 1'b1;
        cur_sel    = tap_q[i];
      end
      if (REQ_LANE == LANE_W'(i)) begin
        req_oh[i] = 1'b1;
        req_cur   = tap_q[i];
      end
    end
  end

  // Widened compares keep the range checks meaningful for any parameter set.
  assign req_legal  = ({1'b0, REQ_LANE} < (LANE_W+1)'(NUM_LANES)) &&
                      ({1'b0, REQ_TAP} <= (TAP_W+1)'(TAP_MAX));
  assign step_start = !REQ_LOAD && req_legal && (REQ_TAP != req_cur);
  assign oor_now    = |(DELAY_LINE_OUT_OF_RANGE & lane_oh);

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    settle_load = 1'b0;
    move_stb    = '0;
    load_stb    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          accept = 1'b1;
          if (REQ_LOAD)        state_d = ST_LOAD;
          else if (step_start) state_d = ST_MOVE;
          else                 state_d = ST_DONE;
        end
      end
      ST_LOAD: begin
        load_stb    = lane_oh;
        settle_load = 1'b1;
        state_d     = ST_SETTLE;
      end
      ST_MOVE: begin
        move_stb    = lane_oh;
        settle_load = 1'b1;
        state_d     = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_tc) begin
          if (err_q || oor_now || load_q || (cur_sel == target_q)) state_d = ST_DONE;
          else                                                     state_d = ST_MOVE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: the per-lane tap array is a handful of flops, so it is reset explicitly lane by lane.
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      lane_q   <= '0;
      load_q   <= 1'b0;
      target_q <= '0;
      err_q    <= 1'b0;
      dir_q    <= '1;
      oor_q    <= '0;
      for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= TAP_W'(INIT_TAP);
    end else begin
      if (accept) begin
        lane_q   <= REQ_LANE;
        load_q   <= REQ_LOAD;
        target_q <= REQ_TAP;
        err_q    <= !REQ_LOAD && !req_legal;
      end else if ((state_q == ST_SETTLE) && oor_now) begin
        err_q <= 1'b1;
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        if (accept && step_start && req_oh[i])
          dir_q[i] <= (REQ_TAP > req_cur) ? DIR_INC : DIR_DEC;
        if (load_stb[i]) begin
          tap_q[i] <= TAP_W'(INIT_TAP);
          oor_q[i] <= 1'b0;
        end else if (move_stb[i]) begin
          tap_q[i] <= (dir_q[i] == DIR_INC) ? tap_q[i] + TAP_W'(1) : tap_q[i] - TAP_W'(1);
        end
        if ((state_q == ST_SETTLE) && lane_oh[i] && DELAY_LINE_OUT_OF_RANGE[i])
          oor_q[i] <= 1'b1;
      end
    end
  end

  ddrphy_dly_settle_cnt #(.CNT_W(CNT_W)) u_settle_cnt (
    .clk      (FAB_CLK),
    .sync_rst (SYNC_RST),
    .load     (settle_load),
    .load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .en       (state_q == ST_SETTLE),
    .tc       (settle_tc)
  );

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_cur_tap
    assign CUR_TAP[tap_lsb(g, TAP_W) +: TAP_W] = tap_q[g];
  end

  assign REQ_READY            = (state_q == ST_IDLE);
  assign DONE                 = (state_q == ST_DONE);
  assign DONE_ERR             = (state_q == ST_DONE) && err_q;
  assign DELAY_LINE_MOVE      = move_stb;
  assign DELAY_LINE_LOAD      = load_stb;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign OOR_STICKY           = oor_q;

endmodule

// File: tb/tb_ddrphy_lane_delay_ctrl.sv
// Self-checking bench for ddrphy_lane_delay_ctrl: directed scenarios plus random requests
// compared cycle by cycle against an arithmetic model of the request timeline.
module tb_ddrphy_lane_delay_ctrl;

  localparam int N    = 4;
  localparam int TW   = 8;
  localparam int TMAX = 127;
  localparam int INIT = 1;
  localparam int S    = 4;
  localparam int LW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid, ready, load, done, derr;
  logic [LW-1:0]     lane;
  logic [TW-1:0]     tap;
  logic [N-1:0]      mv, dir, ld, oor, sticky;
  logic [N*TW-1:0]   cur;

  int checks   = 0;
  int failures = 0;

  int m_tap    [N];
  bit m_sticky [N];
  bit m_dir    [N];

  always #5 clk = ~clk;

  ddrphy_lane_delay_ctrl #(
    .NUM_LANES(N), .TAP_W(TW), .TAP_MAX(TMAX), .INIT_TAP(INIT), .SETTLE_CYCLES(S)
  ) dut (
    .FAB_CLK                 (clk),
    .SYNC_RST                (rst),
    .REQ_VALID               (valid),
    .REQ_READY               (ready),
    .REQ_LANE                (lane),
    .REQ_LOAD                (load),
    .REQ_TAP                 (tap),
    .DONE                    (done),
    .DONE_ERR                (derr),
    .DELAY_LINE_MOVE         (mv),
    .DELAY_LINE_DIRECTION    (dir),
    .DELAY_LINE_LOAD         (ld),
    .DELAY_LINE_OUT_OF_RANGE (oor),
    .CUR_TAP                 (cur),
    .OOR_STICKY              (sticky)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_tap[i]    = INIT;
      m_sticky[i] = 1'b0;
      m_dir[i]    = 1'b1;
    end
  endtask

  function automatic logic [N*TW-1:0] exp_cur();
    logic [N*TW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*TW +: TW] = TW'(m_tap[i]);
    return v;
  endfunction

  function automatic logic [N-1:0] pack_bits(input bit b [N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = b[i];
    return v;
  endfunction

  // Full idle-state snapshot: ready, done, err, strobes, direction, taps, sticky.
  task automatic check_idle(input string tag);
    check(tag, {ready, done, derr, mv, ld, dir, cur, sticky},
               {1'b1, 1'b0, 1'b0, {N{1'b0}}, {N{1'b0}}, pack_bits(m_dir), exp_cur(), pack_bits(m_sticky)});
  endtask

  // Issue one request (called just after a falling edge; accepted on the next rising edge,
  // which closes cycle 0). inj>0 raises OUT_OF_RANGE on the target lane during cycle inj.
  task automatic run_req(input int r_lane, input bit r_load, input int r_tap, input int inj,
                         input string tag);
    int cur_t, n, kerr, steps, exp_done, k, pos;
    bit illegal, exp_err, is_strobe;
    logic [N-1:0] oh, exp_mv, exp_ld;
    oh      = N'(1) << r_lane;
    cur_t   = m_tap[r_lane];
    illegal = !r_load && (r_lane >= N || r_tap > TMAX);
    if (r_load)       n = 1;
    else if (illegal) n = 0;
    else              n = (r_tap > cur_t) ? r_tap - cur_t : cur_t - r_tap;
    kerr = -1;
    if (inj > 0 && n > 0) begin
      k   = (inj - 1) / (S + 1);
      pos = (inj - 1) % (S + 1);
      if (pos != 0 && k < n) kerr = k;
    end
    steps    = (kerr >= 0) ? kerr + 1 : n;
    exp_done = steps * (S + 1) + 1;
    exp_err  = illegal || (kerr >= 0);

    valid = 1'b1;
    lane  = LW'(r_lane);
    load  = r_load;
    tap   = TW'(r_tap);
    @(posedge clk); #1;
    valid = 1'b0;
    lane  = LW'($urandom);
    tap   = TW'($urandom);
    for (int c = 1; c <= exp_done; c++) begin
      oor = ((c == inj) ? oh : '0) | (N'($urandom) & ~oh);
      @(negedge clk);
      is_strobe = ((c - 1) % (S + 1) == 0) && ((c - 1) / (S + 1) < steps);
      exp_mv    = (!r_load && is_strobe) ? oh : '0;
      exp_ld    = (r_load && is_strobe) ? oh : '0;
      check($sformatf("%s_c%0d", tag, c), {ready, done, derr, mv, ld},
            {1'b0, c == exp_done, (c == exp_done) && exp_err, exp_mv, exp_ld});
      @(posedge clk); #1;
    end
    oor = '0;

    if (r_load) begin
      m_tap[r_lane]    = INIT;
      m_sticky[r_lane] = (kerr >= 0);
    end else if (!illegal && n > 0) begin
      m_dir[r_lane] = (r_tap > cur_t);
      m_tap[r_lane] = m_dir[r_lane] ? cur_t + steps : cur_t - steps;
      if (kerr >= 0) m_sticky[r_lane] = 1'b1;
    end
    @(negedge clk);
    check_idle({tag, "_after"});
  endtask

  initial begin
    int r_lane, r_kind, r_tap, r_inj, t;
    rst   = 1'b1;
    valid = 1'b0;
    lane  = '0;
    load  = 1'b0;
    tap   = '0;
    oor   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: nothing moves for 20 cycles, even with OUT_OF_RANGE toggling.
    for (int i = 0; i < 20; i++) begin
      oor = N'($urandom);
      @(negedge clk);
      check($sformatf("idle_%0d", i), {ready, done, derr, mv, ld, dir, cur, sticky},
            {1'b1, 1'b0, 1'b0, {N{1'b0}}, {N{1'b0}}, {N{1'b1}}, exp_cur(), {N{1'b0}}});
    end
    oor = '0;

    run_req(2, 1'b0, 4,   0,  "up3");
    run_req(2, 1'b0, 2,   0,  "down2");
    run_req(1, 1'b0, 128, 0,  "illegal_tap");
    run_req(1, 1'b0, 1,   0,  "zero_dist");
    run_req(0, 1'b0, 10,  12, "oor_3rd_settle");
    run_req(0, 1'b1, 0,   0,  "load0");
    run_req(1, 1'b0, 3,   2,  "oor_1st_settle");
    run_req(1, 1'b0, 5,   6,  "oor_on_strobe");

    // Reset while settling during a 5-step move.
    valid = 1'b1;
    lane  = LW'(3);
    load  = 1'b0;
    tap   = TW'(6);
    @(posedge clk); #1;
    valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_pre_c%0d", c), {done, derr}, 2'b00);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_idle("rst_after");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("rst_quiet_%0d", i), {ready, done, mv, ld}, {1'b1, 1'b0, {N{1'b0}}, {N{1'b0}}});
    end

    run_req(3, 1'b0, TMAX,     0, "to_max");
    run_req(3, 1'b0, TMAX + 1, 0, "over_max");
    run_req(3, 1'b0, TMAX,     0, "at_max");
    run_req(3, 1'b1, 0,        0, "load3");
    run_req(2, 1'b0, 0,        0, "to_zero");

    for (int i = 0; i < 40; i++) begin
      r_lane = $urandom_range(0, N - 1);
      r_kind = $urandom_range(0, 9);
      if (r_kind == 1) r_tap = $urandom_range(TMAX + 1, 255);
      else begin
        t = m_tap[r_lane] + int'($urandom_range(0, 8)) - 4;
        if (t < 0)    t = 0;
        if (t > TMAX) t = TMAX;
        r_tap = t;
      end
      r_inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
      run_req(r_lane, r_kind == 0, r_tap, r_inj, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddrphy_lane_delay_ctrl.md
Name: ddrphy_lane_delay_ctrl

Overview:
Multi-lane delay-line tap controller for the LPDDR3 DDRPHY command/CKE IOD lanes. It accepts one request at a time over a valid/ready handshake, either to load a lane to its initial tap or to step a lane to a target tap. It drives per-lane DELAY_LINE_MOVE, DIRECTION and LOAD strobes into the IODs and tracks the current tap count of each lane. It monitors DELAY_LINE_OUT_OF_RANGE and reports a sticky per-lane error.

Parameters:
NUM_LANES, 4, number of IOD lanes controlled (>=1)
TAP_W, 8, tap counter width
TAP_MAX, 127, highest legal tap value (< 2**TAP_W)
INIT_TAP, 1, tap value after LOAD and after reset
SETTLE_CYCLES, 4, idle cycles after each strobe before the next strobe or completion (>=1)
LANE_W, max(1,$clog2(NUM_LANES)), lane index width (derived)

Ports:
FAB_CLK  in  1  fabric clock; all logic rising-edge
SYNC_RST  in  1  synchronous active-high reset
REQ_VALID  in  1  request valid
REQ_READY  out  1  controller idle, request accepted when VALID&READY
REQ_LANE  in  LANE_W  target lane index
REQ_LOAD  in  1  1=load lane to INIT_TAP, 0=step to REQ_TAP
REQ_TAP  in  TAP_W  target tap (ignored when REQ_LOAD=1)
DONE  out  1  one-cycle completion pulse
DONE_ERR  out  1  valid with DONE; request failed
DELAY_LINE_MOVE  out  NUM_LANES  per-lane one-cycle step strobe
DELAY_LINE_DIRECTION  out  NUM_LANES  per-lane direction, 1=increment, registered
DELAY_LINE_LOAD  out  NUM_LANES  per-lane one-cycle load strobe
DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane IOD out-of-range flag
CUR_TAP  out  NUM_LANES*TAP_W  packed current tap per lane, lane0 in LSBs
OOR_STICKY  out  NUM_LANES  per-lane sticky out-of-range

Behaviour:
- Reset: FSM=IDLE. REQ_READY=1. DONE=DONE_ERR=0. MOVE=LOAD=0. DIRECTION=all 1. CUR_TAP=INIT_TAP for every lane. OOR_STICKY=0. Reset mid-operation aborts immediately; no DONE is issued.
- FSM states: IDLE, LOAD, MOVE, SETTLE, DONE. REQ_READY=1 only in IDLE.
- IDLE, on accept (cycle 0): latch lane, load flag and target. Then:
  - REQ_LOAD=1 -> LOAD.
  - REQ_LANE>=NUM_LANES or REQ_TAP>TAP_MAX -> DONE with err. No strobes, no state change.
  - REQ_TAP==CUR_TAP[lane] -> DONE, no err.
  - Otherwise DIRECTION[lane]<=(REQ_TAP>CUR_TAP) -> MOVE.
- LOAD: DELAY_LINE_LOAD[lane]=1 for exactly one cycle; CUR_TAP[lane]<=INIT_TAP; OOR_STICKY[lane]<=0; -> SETTLE.
- MOVE: DELAY_LINE_MOVE[lane]=1 for exactly one cycle; CUR_TAP[lane] +/-1 per DIRECTION; -> SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles. Any cycle in SETTLE with OUT_OF_RANGE[lane]=1 sets OOR_STICKY[lane] and a pending error. On the last SETTLE cycle:
  - pending error -> DONE with err. CUR_TAP keeps the value already counted.
  - load done, or CUR_TAP==target -> DONE.
  - else -> MOVE.
- DONE: DONE=1 for one cycle, DONE_ERR as determined; -> IDLE.
- Latency from accept at cycle 0:
  - n-step move: MOVE strobes at cycles 1+k*(S+1), k=0..n-1; DONE at cycle n*(S+1)+1 (S=SETTLE_CYCLES).
  - Load: LOAD at cycle 1, DONE at S+2.
  - Zero-distance or illegal request: DONE at cycle 1.
- Only the latched lane is ever strobed. Other lanes' outputs and CUR_TAP remain stable.
- OUT_OF_RANGE outside SETTLE is ignored. OOR_STICKY is cleared only by reset or LOAD of that lane.
- CUR_TAP never wraps: target is range-checked on accept, so no step exceeds 0..TAP_MAX.

Decomposition:
- Package ddrphy_dly_pkg: FSM state enum, DIR_INC/DIR_DEC constants, and a tap-index helper function for the packed CUR_TAP slice.
- One natural sub-module, ddrphy_dly_settle_cnt: a loadable down-counter that provides the SETTLE terminal count.
- The FSM and the per-lane tap registers stay in the top module.

Test Plan:
- Reset then idle: CUR_TAP lanes all =1, REQ_READY=1, all strobes 0 -> no DONE, outputs stable for 20 cycles.
- Lane 2, REQ_TAP=4, S=4 -> 3 MOVE pulses on bit 2 only at cycles 1, 6, 11; DIRECTION[2]=1; DONE at 16, DONE_ERR=0; CUR_TAP[2]=4.
- Lane 2, REQ_TAP=2 from 4 -> DIRECTION[2]=0; 2 MOVE pulses; DONE at 11; CUR_TAP[2]=2.
- Lane 1, REQ_TAP=128 (>TAP_MAX) -> DONE+DONE_ERR at cycle 1, no strobes, CUR_TAP unchanged. Repeat with REQ_TAP equal to the current tap -> DONE at cycle 1, no err.
- Lane 0, target 10; OUT_OF_RANGE[0]=1 during the 3rd SETTLE -> DONE_ERR=1, CUR_TAP[0]=4, OOR_STICKY[0]=1. Then REQ_LOAD lane 0 -> LOAD pulse at cycle 1, DONE at 6, CUR_TAP[0]=1, OOR_STICKY[0]=0.
- SYNC_RST asserted during SETTLE of a 5-step move -> no DONE, all taps back to 1, REQ_READY=1 the cycle after reset deasserts.
